crc4_checker: RTL and testbench

//  Receive-side counterpart of the team's combinational CRC4 encoder.

---
 rtl/crc4_checker.sv | 195 +++++++++++++++++++
 tb/tb_crc4_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/crc4_checker.sv
// crc4_checker: serial CRC4 receive-side checker.
// Divides a 14-bit codeword {data, crc} by a 5-bit generator polynomial, MSB first,
// with a 4-bit LFSR. It reports the syndrome, pass/fail and the recovered data field.
// Optional build macro CRC4_CORRECT_EN adds a SEARCH state. That state locates and
// flips a single erroneous bit by stepping x^j mod poly until it equals the syndrome.
module crc4_checker #(
   parameter int DATA_W = 10,
   parameter int CRC_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W+CRC_W-1:0] codeword_in,
   input  logic [CRC_W:0]      poly_in,
   output logic                out_valid,
   output logic [DATA_W-1:0]   data_out,
   output logic [CRC_W-1:0]    syndrome,
   output logic                crc_ok,
   output logic                crc_err,
   output logic                corrected,
   output logic [3:0]          err_pos
);

   localparam int CW_W = DATA_W + CRC_W;
   localparam logic [3:0] LAST_IDX = 4'(CW_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_EVAL,
`ifdef CRC4_CORRECT_EN
      S_SEARCH,
`endif
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [CW_W-1:0]   cw_q;
   logic [CRC_W:0]    poly_q;
   logic [CRC_W-1:0]  rem_q;
   logic [3:0]        cnt_q;

   logic              take;
   logic              load_res;
   logic              res_ok;
   logic              res_err;
   logic              res_corr;
   logic [3:0]        res_pos;
   logic [DATA_W-1:0] res_data;

`ifdef CRC4_CORRECT_EN
   logic [CRC_W-1:0]  s_q;
   logic [3:0]        j_q;
   logic [CW_W-1:0]   cw_fix;

   // Candidate codeword with bit j flipped, used when the search finds a match
   always_comb begin
      cw_fix = cw_q ^ (CW_W'(1) << j_q);
   end
`endif

   // Next-state and handshake/result decode; results are committed on the edge into DONE
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      take      = 1'b0;
      load_res  = 1'b0;
      res_ok    = 1'b0;
      res_err   = 1'b0;
      res_corr  = 1'b0;
      res_pos   = 4'd0;
      res_data  = cw_q[CW_W-1:CRC_W];
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               take    = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt_q == 4'd0) state_d = S_EVAL;
         end
         S_EVAL: begin
            if (!poly_q[CRC_W]) begin
               // A polynomial without its top term is not a degree-4 generator
               load_res = 1'b1;
               res_err  = 1'b1;
               state_d  = S_DONE;
            end else if (rem_q == '0) begin
               load_res = 1'b1;
               res_ok   = 1'b1;
               state_d  = S_DONE;
            end else begin
`ifdef CRC4_CORRECT_EN
               state_d  = S_SEARCH;
`else
               load_res = 1'b1;
               res_err  = 1'b1;
               state_d  = S_DONE;
`endif
            end
         end
`ifdef CRC4_CORRECT_EN
         S_SEARCH: begin
            if (s_q == rem_q) begin
               load_res = 1'b1;
               res_corr = 1'b1;
               res_pos  = j_q;
               res_data = cw_fix[CW_W-1:CRC_W];
               state_d  = S_DONE;
            end else if (j_q == LAST_IDX) begin
               // Syndrome is not x^j for any bit position: more than one bit is wrong
               load_res = 1'b1;
               res_err  = 1'b1;
               state_d  = S_DONE;
            end
         end
`endif
         S_DONE: begin
            out_valid = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register and bit counter; reset aborts any job in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         if (take) begin
            cnt_q <= LAST_IDX;
         end else if (state_q == S_SHIFT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end

   // Job capture and serial polynomial division, one codeword bit per SHIFT cycle
   always_ff @(posedge clk) begin
      if (take) begin
         cw_q   <= codeword_in;
         poly_q <= poly_in;
         rem_q  <= '0;
      end else if (state_q == S_SHIFT) begin
         rem_q <= {rem_q[CRC_W-2:0], cw_q[cnt_q]}
                  ^ (rem_q[CRC_W-1] ? poly_q[CRC_W-1:0] : '0);
      end
   end

`ifdef CRC4_CORRECT_EN
   // Error-locator walk: s tracks x^j mod poly while j steps through bit positions
   always_ff @(posedge clk) begin
      if (rst) begin
         j_q <= 4'd0;
      end else if (state_q == S_EVAL) begin
         j_q <= 4'd0;
      end else if (state_q == S_SEARCH) begin
         j_q <= j_q + 4'd1;
      end
      if (state_q == S_EVAL) begin
         s_q <= {{(CRC_W-1){1'b0}}, 1'b1};
      end else if (state_q == S_SEARCH) begin
         s_q <= {s_q[CRC_W-2:0], 1'b0} ^ (s_q[CRC_W-1] ? poly_q[CRC_W-1:0] : '0);
      end
   end
`endif

   // Result registers: updated once per job, held until the next out_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out  <= '0;
         syndrome  <= '0;
         crc_ok    <= 1'b0;
         crc_err   <= 1'b0;
         corrected <= 1'b0;
         err_pos   <= 4'd0;
      end else if (load_res) begin
         data_out  <= res_data;
         syndrome  <= rem_q;
         crc_ok    <= res_ok;
         crc_err   <= res_err;
         corrected <= res_corr;
         err_pos   <= res_pos;
      end
   end

endmodule

// File: tb/tb_crc4_checker.sv
// Scoreboard bench for crc4_checker: the driver pushes hand-computed expectations,
// and an independent monitor pops and compares them on every out_valid pulse.
module tb_crc4_checker;

`ifdef CRC4_CORRECT_EN
   localparam bit CORR = 1'b1;
`else
   localparam bit CORR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [13:0] codeword_in = '0;
   logic [4:0]  poly_in = '0;
   logic        out_valid;
   logic [9:0]  data_out;
   logic [3:0]  syndrome;
   logic        crc_ok;
   logic        crc_err;
   logic        corrected;
   logic [3:0]  err_pos;

   crc4_checker dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .codeword_in (codeword_in),
      .poly_in     (poly_in),
      .out_valid   (out_valid),
      .data_out    (data_out),
      .syndrome    (syndrome),
      .crc_ok      (crc_ok),
      .crc_err     (crc_err),
      .corrected   (corrected),
      .err_pos     (err_pos)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [9:0] data;
      logic [3:0] syn;
      logic       ok;
      logic       err;
      logic       corr;
      logic [3:0] pos;
      int         lat;
      int         t0;
   } exp_t;

   exp_t sbq[$];
   int tests = 0;
   int fails = 0;
   int pulses = 0;
   int sent = 0;
   int last_t0 = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Present one job and wait (bounded) for its transfer edge, then log the expectation
   task automatic send(input logic [13:0] cw, input logic [4:0] p,
                       input logic [9:0] d, input logic [3:0] syn,
                       input logic ok, input logic err, input logic corr,
                       input logic [3:0] pos, input int lat);
      exp_t e;
      int n;
      codeword_in = cw;
      poly_in     = p;
      in_valid    = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: cw 0x%0h not accepted within 100 cycles", cw);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.data = d; e.syn = syn; e.ok = ok; e.err = err; e.corr = corr;
      e.pos = pos; e.lat = lat; e.t0 = cyc;
      last_t0 = cyc;
      sbq.push_back(e);
      sent++;
      @(negedge clk);
   endtask

   // Monitor: every out_valid pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid) begin
         pulses++;
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out_valid: pulse at cycle %0d, expected none", cyc);
         end else begin
            e = sbq.pop_front();
            chk("data_out",  data_out,  e.data);
            chk("syndrome",  syndrome,  e.syn);
            chk("crc_ok",    crc_ok,    e.ok);
            chk("crc_err",   crc_err,   e.err);
            chk("corrected", corrected, e.corr);
            chk("err_pos",   err_pos,   e.pos);
            chk("latency",   cyc - e.t0, e.lat);
            chk("in_ready_in_done", in_ready, 0);
         end
      end
   end

   initial begin
      int t_a;
      int n;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data_out",  data_out,  0);
      chk("rst_syndrome",  syndrome,  0);
      chk("rst_flags",     {crc_ok, crc_err, corrected, err_pos}, 0);
      rst = 1'b0;
      @(negedge clk);

      // Clean codewords
      send(14'h2C7D, 5'h13, 10'h2C7, 4'h0, 1, 0, 0, 4'd0, 15);
      in_valid = 1'b0;
      send(14'h287A, 5'h13, 10'h287, 4'h0, 1, 0, 0, 4'd0, 15);
      send(14'h285C, 5'h15, 10'h285, 4'h0, 1, 0, 0, 4'd0, 15);
      send(14'h2008, 5'h18, 10'h200, 4'h0, 1, 0, 0, 4'd0, 15);
      in_valid = 1'b0;

      // Single-bit errors: bit 5, bit 0, bit 12, bit 13
      send(14'h2C5D, 5'h13, CORR ? 10'h2C7 : 10'h2C5, 4'h6, 0, !CORR, CORR,
           CORR ? 4'd5 : 4'd0, CORR ? 21 : 15);
      send(14'h2C7C, 5'h13, 10'h2C7, 4'h1, 0, !CORR, CORR, 4'd0, CORR ? 16 : 15);
      send(14'h3C7D, 5'h13, CORR ? 10'h2C7 : 10'h3C7, 4'hF, 0, !CORR, CORR,
           CORR ? 4'd12 : 4'd0, CORR ? 28 : 15);
      send(14'h0C7D, 5'h13, CORR ? 10'h2C7 : 10'h0C7, 4'hD, 0, !CORR, CORR,
           CORR ? 4'd13 : 4'd0, CORR ? 29 : 15);
      // Syndrome 9 = x^14 mod poly: no bit position matches, search exhausts
      send(14'h2C74, 5'h13, 10'h2C7, 4'h9, 0, 1, 0, 4'd0, CORR ? 29 : 15);

      // Invalid polynomial (bit 4 clear), with zero and nonzero remainder
      send(14'h0000, 5'h03, 10'h000, 4'h0, 0, 1, 0, 4'd0, 15);
      send(14'h0003, 5'h03, 10'h000, 4'h3, 0, 1, 0, 4'd0, 15);
      in_valid = 1'b0;

      // Reset in the middle of SHIFT discards the job
      n = 0;
      while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
      send(14'h2C7D, 5'h13, 10'h2C7, 4'h0, 1, 0, 0, 4'd0, 15);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      if (sbq.size() != 0) begin
         void'(sbq.pop_back());
         sent--;
      end
      chk("midrst_in_ready",  in_ready,  1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_data_out",  data_out,  0);
      chk("midrst_syndrome",  syndrome,  0);
      chk("midrst_flags",     {crc_ok, crc_err, corrected, err_pos}, 0);
      repeat (25) @(negedge clk);
      send(14'h287A, 5'h13, 10'h287, 4'h0, 1, 0, 0, 4'd0, 15);
      in_valid = 1'b0;

      // in_valid held high across two jobs: second accepted right after DONE
      n = 0;
      while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
      send(14'h2C7D, 5'h13, 10'h2C7, 4'h0, 1, 0, 0, 4'd0, 15);
      t_a = last_t0;
      send(14'h285C, 5'h15, 10'h285, 4'h0, 1, 0, 0, 4'd0, 15);
      chk("b2b_accept_gap", last_t0 - t_a, 17);
      in_valid = 1'b0;

      // Drain
      n = 0;
      while (sbq.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("drain_outstanding", sbq.size(), 0);
      repeat (20) @(negedge clk);
      chk("pulse_count", pulses, sent);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
